// File: rtl/ysyx_040066_trap_ctrl_pkg.sv
// Shared definitions for the trap sequencer: FSM encoding, cause values
// and CSR bit positions.
package ysyx_040066_trap_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_TAKE  = 3'd2,
        ST_RET   = 3'd3,
        ST_FLUSH = 3'd4
    } trap_state_e;

    localparam logic [63:0] CAUSE_TIMER_IRQ = 64'h8000_0000_0000_0007;

    localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_ECALL_M     = 4'd11;

    localparam int MSTATUS_MIE = 3;
    localparam int MIE_MTIE    = 7;

endpackage

// File: rtl/ysyx_040066_sat_cnt.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
// With EN=0 the output is tied to zero and no flops are built.
module ysyx_040066_sat_cnt #(
    parameter int W  = 32,
    parameter bit EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    if (EN) begin : g_cnt
        logic [W-1:0] cnt_q;
        logic [W-1:0] cnt_d;

        // next value: hold once all-ones is reached
        always_comb begin
            cnt_d = cnt_q;
            if (inc && (cnt_q != {W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // counter register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt = cnt_q;
    end else begin : g_tie
        logic unused_cnt;
        assign unused_cnt = clk ^ rst ^ inc;
        assign cnt        = '0;
    end

endmodule

// File: rtl/ysyx_040066_trap_ctrl.sv
// Trap sequencer in front of the machine-mode CSR file. Arbitrates
// exceptions, mret and the machine timer interrupt, stalls until memory is
// quiescent, strobes the CSR when no CSR write can collide, then flushes.
// Optional perf counters are built when TRAP_PERF_EN is defined.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no trap in progress, arbitrate exc > mret > timer irq
// DRAIN | trap latched, waiting for pipe_idle
// TAKE  | raise_intr to CSR unless a CSR write owns this cycle
// RET   | ret to CSR unless a CSR write owns this cycle
// FLUSH | one-cycle pipeline kill, fetch follows CSR jmp/nxtpc
module ysyx_040066_trap_ctrl
    import ysyx_040066_trap_ctrl_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exc_valid,
    input  logic [3:0]       exc_code,
    input  logic [XLEN-1:0]  exc_pc,
    input  logic [XLEN-1:0]  exc_tval,
    input  logic             mret_valid,
    input  logic             commit_valid,
    input  logic [XLEN-1:0]  commit_npc,
    input  logic             timer_irq,
    input  logic [XLEN-1:0]  mstatus,
    input  logic [XLEN-1:0]  mie,
    input  logic             csr_wen,
    input  logic             pipe_idle,
    output logic             stall,
    output logic             flush,
    output logic             raise_intr,
    output logic [XLEN-1:0]  NO,
    output logic [XLEN-1:0]  tval,
    output logic [XLEN-1:0]  pc,
    output logic             ret,
    output logic             clear_mip,
    output logic [CNT_W-1:0] exc_cnt,
    output logic [CNT_W-1:0] irq_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    trap_state_e     state_q, state_d;
    logic            stall_q, stall_d;
    logic            flush_q, flush_d;
    logic [XLEN-1:0] no_q, no_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic            is_irq_q, is_irq_d;
    logic            tirq_q, tirq_d;
    logic            clr_pend_q, clr_pend_d;
    logic            irq_take;
    logic            tirq_fall;

    assign irq_take = timer_irq & mstatus[MSTATUS_MIE] & mie[MIE_MTIE] & commit_valid;

    // CSR strobes are withheld while a CSR instruction writes, since the
    // CSR file gives its write port priority and would drop the trap.
    assign raise_intr = (state_q == ST_TAKE) & ~csr_wen;
    assign ret        = (state_q == ST_RET) & ~csr_wen;

    // A falling timer edge queues one clear_mip; it waits out a raise_intr.
    assign tirq_fall = tirq_q & ~timer_irq;
    assign clear_mip = clr_pend_q & ~raise_intr;

    // next-state, trap latch and registered output computation
    always_comb begin
        state_d    = state_q;
        no_d       = no_q;
        pc_d       = pc_q;
        tval_d     = tval_q;
        is_irq_d   = is_irq_q;
        tirq_d     = timer_irq;
        clr_pend_d = tirq_fall | (clr_pend_q & raise_intr);
        case (state_q)
            ST_IDLE: begin
                if (exc_valid) begin
                    no_d     = XLEN'(exc_code);
                    pc_d     = exc_pc;
                    tval_d   = exc_tval;
                    is_irq_d = 1'b0;
                    state_d  = ST_DRAIN;
                end else if (mret_valid) begin
                    state_d = ST_RET;
                end else if (irq_take) begin
                    no_d     = XLEN'(CAUSE_TIMER_IRQ);
                    pc_d     = commit_npc;
                    tval_d   = '0;
                    is_irq_d = 1'b1;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: if (pipe_idle) state_d = ST_TAKE;
            ST_TAKE:  if (!csr_wen)  state_d = ST_FLUSH;
            ST_RET:   if (!csr_wen)  state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        stall_d = (state_d != ST_IDLE);
        flush_d = (state_d == ST_FLUSH);
    end

    // sequencer state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            stall_q    <= 1'b0;
            flush_q    <= 1'b0;
            no_q       <= '0;
            pc_q       <= '0;
            tval_q     <= '0;
            is_irq_q   <= 1'b0;
            tirq_q     <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            no_q       <= no_d;
            pc_q       <= pc_d;
            tval_q     <= tval_d;
            is_irq_q   <= is_irq_d;
            tirq_q     <= tirq_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    assign stall = stall_q;
    assign flush = flush_q;
    assign NO    = no_q;
    assign pc    = pc_q;
    assign tval  = tval_q;

    // only bit 3 of mstatus and bit 7 of mie matter here
    logic unused_csr;
    assign unused_csr = ^mstatus ^ ^mie;

`ifdef TRAP_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    ysyx_040066_sat_cnt #(.W(CNT_W), .EN(PERF_EN)) u_exc_cnt (
        .clk (clk),
        .rst (rst),
        .inc (raise_intr & ~is_irq_q),
        .cnt (exc_cnt)
    );

    ysyx_040066_sat_cnt #(.W(CNT_W), .EN(PERF_EN)) u_irq_cnt (
        .clk (clk),
        .rst (rst),
        .inc (raise_intr & is_irq_q),
        .cnt (irq_cnt)
    );

    ysyx_040066_sat_cnt #(.W(CNT_W), .EN(PERF_EN)) u_ret_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ret),
        .cnt (ret_cnt)
    );

endmodule

// File: tb/tb_ysyx_040066_trap_ctrl.sv
// Bench for the trap sequencer: transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_ysyx_040066_trap_ctrl;
    import ysyx_040066_trap_ctrl_pkg::*;

    localparam int XLEN  = 64;
    localparam int CNT_W = 32;
`ifdef TRAP_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             exc_valid, mret_valid, commit_valid, timer_irq, csr_wen, pipe_idle;
    logic [3:0]       exc_code;
    logic [XLEN-1:0]  exc_pc, exc_tval, commit_npc, mstatus, mie;
    logic             stall, flush, raise_intr, ret, clear_mip;
    logic [XLEN-1:0]  NO, tval, pc;
    logic [CNT_W-1:0] exc_cnt, irq_cnt, ret_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_040066_trap_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret_valid(mret_valid), .commit_valid(commit_valid), .commit_npc(commit_npc),
        .timer_irq(timer_irq), .mstatus(mstatus), .mie(mie),
        .csr_wen(csr_wen), .pipe_idle(pipe_idle),
        .stall(stall), .flush(flush), .raise_intr(raise_intr),
        .NO(NO), .tval(tval), .pc(pc), .ret(ret), .clear_mip(clear_mip),
        .exc_cnt(exc_cnt), .irq_cnt(irq_cnt), .ret_cnt(ret_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model (transaction view) ----------------
    // busy: a trap/return transaction owns the pipeline
    // drained: memory has gone quiet for this trap
    // done: CSR strobe delivered, only the flush cycle remains
    logic             m_busy, m_mret, m_irq, m_drained, m_done;
    logic [XLEN-1:0]  m_no, m_pc, m_tval;
    logic             m_prev_tirq, m_pend;
    logic [CNT_W-1:0] m_exc, m_irqc, m_ret;

    function automatic logic f_raise();
        return m_busy && !m_done && !m_mret && m_drained && !csr_wen;
    endfunction

    function automatic logic f_ret();
        return m_busy && !m_done && m_mret && !csr_wen;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_mret = 0; m_irq = 0; m_drained = 0; m_done = 0;
            m_no = 0; m_pc = 0; m_tval = 0;
            m_prev_tirq = 0; m_pend = 0;
            m_exc = 0; m_irqc = 0; m_ret = 0;
        end else begin
            logic r, t;
            r = f_raise();
            t = f_ret();
            if (r && !m_irq && m_exc != {CNT_W{1'b1}}) m_exc = m_exc + 1;
            if (r && m_irq && m_irqc != {CNT_W{1'b1}}) m_irqc = m_irqc + 1;
            if (t && m_ret != {CNT_W{1'b1}}) m_ret = m_ret + 1;
            m_pend = (m_prev_tirq && !timer_irq) || (m_pend && r);
            m_prev_tirq = timer_irq;
            if (!m_busy) begin
                if (exc_valid) begin
                    m_busy = 1; m_mret = 0; m_irq = 0; m_drained = 0; m_done = 0;
                    m_no = {60'b0, exc_code}; m_pc = exc_pc; m_tval = exc_tval;
                end else if (mret_valid) begin
                    m_busy = 1; m_mret = 1; m_drained = 0; m_done = 0;
                end else if (timer_irq && mstatus[3] && mie[7] && commit_valid) begin
                    m_busy = 1; m_mret = 0; m_irq = 1; m_drained = 0; m_done = 0;
                    m_no = 64'h8000_0000_0000_0007; m_pc = commit_npc; m_tval = 0;
                end
            end else if (m_done) begin
                m_busy = 0;
            end else if (!m_mret && !m_drained) begin
                m_drained = pipe_idle;
            end else if (r || t) begin
                m_done = 1;
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_stall", stall, m_busy);
            chk("m_flush", flush, m_busy && m_done);
            chk("m_raise", raise_intr, f_raise());
            chk("m_ret", ret, f_ret());
            chk("m_clear_mip", clear_mip, m_pend && !f_raise());
            chk("m_NO", NO, m_no);
            chk("m_pc", pc, m_pc);
            chk("m_tval", tval, m_tval);
            chk("m_exc_cnt", exc_cnt, PERF ? m_exc : 0);
            chk("m_irq_cnt", irq_cnt, PERF ? m_irqc : 0);
            chk("m_ret_cnt", ret_cnt, PERF ? m_ret : 0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_exc(input logic [3:0] code, input logic [63:0] pcv);
        exc_valid = 1; exc_code = code; exc_pc = pcv; exc_tval = 0; pipe_idle = 1;
        repeat (4) cyc();
        exc_valid = 0;
        cyc();
    endtask

    task automatic run_mret();
        mret_valid = 1;
        repeat (3) cyc();
        mret_valid = 0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; exc_valid = 0; mret_valid = 0; commit_valid = 0; timer_irq = 0;
        csr_wen = 0; pipe_idle = 1; exc_code = 0; exc_pc = 0; exc_tval = 0;
        commit_npc = 0; mstatus = 0; mie = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);
        chk("rst_NO", NO, 0);
        chk("rst_exc_cnt", exc_cnt, 0);
        rst = 0;
        cyc();

        // ecall, pipe already idle
        exc_valid = 1; exc_code = EXC_ECALL_M; exc_pc = 64'h8000_0010; exc_tval = 0; pipe_idle = 1;
        @(negedge clk); chk("ecall_c0_stall", stall, 0);
        cyc(); @(negedge clk); chk("ecall_c1_stall", stall, 1); chk("ecall_c1_raise", raise_intr, 0);
        cyc(); @(negedge clk);
        chk("ecall_c2_raise", raise_intr, 1);
        chk("ecall_c2_NO", NO, 11);
        chk("ecall_c2_pc", pc, 64'h8000_0010);
        chk("ecall_c2_tval", tval, 0);
        cyc(); @(negedge clk); chk("ecall_c3_flush", flush, 1); chk("ecall_c3_stall", stall, 1);
        cyc(); exc_valid = 0;
        @(negedge clk); chk("ecall_c4_stall", stall, 0); chk("ecall_c4_flush", flush, 0);
        cyc();

        // ecall with 5 cycles of outstanding memory traffic
        exc_valid = 1; exc_code = EXC_ECALL_M; exc_tval = 64'h1234; pipe_idle = 0;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            if (c == 6) pipe_idle = 1;
            @(negedge clk);
            chk("drain_stall", stall, 1);
            chk("drain_raise", raise_intr, (c == 7));
        end
        cyc();
        cyc(); exc_valid = 0;
        cyc();

        // timer interrupt, timer drops in the raise_intr cycle
        timer_irq = 1; mstatus = 64'h8; mie = 64'h80; commit_valid = 1;
        commit_npc = 64'h8000_0100; pipe_idle = 1;
        cyc(); commit_valid = 0;
        @(negedge clk); chk("irq_c1_stall", stall, 1);
        cyc(); timer_irq = 0;
        @(negedge clk);
        chk("irq_c2_raise", raise_intr, 1);
        chk("irq_c2_NO", NO, 64'h8000_0000_0000_0007);
        chk("irq_c2_pc", pc, 64'h8000_0100);
        chk("irq_c2_tval", tval, 0);
        chk("irq_c2_clear_mip", clear_mip, 0);
        cyc(); @(negedge clk); chk("irq_c3_flush", flush, 1); chk("irq_c3_clear_mip", clear_mip, 1);
        cyc(); @(negedge clk); chk("irq_c4_clear_mip", clear_mip, 0); chk("irq_c4_stall", stall, 0);
        cyc();

        // timer masked by mstatus.MIE
        timer_irq = 1; mstatus = 64'h0; commit_valid = 1;
        for (int c = 1; c <= 3; c++) begin
            cyc(); @(negedge clk); chk("mask_stall", stall, 0);
        end
        cyc(); timer_irq = 0; commit_valid = 0; mstatus = 64'h8;
        repeat (2) cyc();

        // exc + mret together, CSR write blocks the first two TAKE cycles
        exc_valid = 1; mret_valid = 1; exc_code = EXC_ILLEGAL;
        exc_pc = 64'h8000_0200; exc_tval = 64'hbad; pipe_idle = 1;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            csr_wen = (c == 2 || c == 3);
            if (c == 6) begin exc_valid = 0; mret_valid = 0; end
            @(negedge clk);
            chk("simul_raise", raise_intr, (c == 4));
            chk("simul_ret", ret, 0);
            if (c == 4) chk("simul_NO", NO, 2);
        end
        cyc();

        // mret
        mret_valid = 1;
        cyc(); @(negedge clk); chk("mret_c1_ret", ret, 1); chk("mret_c1_stall", stall, 1);
        cyc(); @(negedge clk); chk("mret_c2_flush", flush, 1); chk("mret_c2_ret", ret, 0);
        cyc(); mret_valid = 0;
        @(negedge clk); chk("mret_c3_stall", stall, 0);
        cyc();

        // reset while draining
        exc_valid = 1; exc_code = EXC_LD_MISALIGN; exc_pc = 64'h8000_0300; pipe_idle = 0;
        cyc(); cyc();
        #2 rst = 1;
        #1;
        chk("rstmid_stall", stall, 0);
        chk("rstmid_NO", NO, 0);
        chk("rstmid_pc", pc, 0);
        chk("rstmid_raise", raise_intr, 0);
        chk("rstmid_exc_cnt", exc_cnt, 0);
        exc_valid = 0; pipe_idle = 1;
        cyc(); cyc(); rst = 0;
        for (int c = 0; c < 4; c++) begin
            cyc(); @(negedge clk);
            chk("rstmid_after_raise", raise_intr, 0);
            chk("rstmid_after_stall", stall, 0);
        end
        cyc();

        // counters: 3 ecalls + 1 mret since reset
        run_exc(EXC_ECALL_M, 64'h8000_0400);
        run_exc(EXC_ECALL_M, 64'h8000_0404);
        run_exc(EXC_ECALL_M, 64'h8000_0408);
        run_mret();
        @(negedge clk);
        chk("perf_exc_cnt", exc_cnt, PERF ? 3 : 0);
        chk("perf_ret_cnt", ret_cnt, PERF ? 1 : 0);
        chk("perf_irq_cnt", irq_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
